// File: rtl/instr_enc_pkg.sv
// Shared constants, state encoding and opcode-word packing for the MSP430 instruction encoder.
// The format codes and prefixes match what the decoder expects on the MDB.
package instr_enc_pkg;

    localparam logic [1:0] FMT_NONE = 2'd0;
    localparam logic [1:0] FMT_I    = 2'd1;
    localparam logic [1:0] FMT_II   = 2'd2;
    localparam logic [1:0] FMT_J    = 2'd3;

    localparam logic [5:0] FMT_II_PREFIX = 6'b000100;
    localparam logic [2:0] JMP_PREFIX    = 3'b001;
    // op[2:0] == 3'b111 has no single-operand instruction behind it
    localparam logic [2:0] FMT_II_RSVD   = 3'b111;

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_OPW  = 2'd1,
        ENC_SRC  = 2'd2,
        ENC_DST  = 2'd3
    } enc_state_e;

    function automatic logic cmd_invalid(input logic [1:0] fmt, input logic [3:0] op);
        return (fmt == FMT_NONE) || ((fmt == FMT_II) && (op[2:0] == FMT_II_RSVD));
    endfunction

    function automatic logic [15:0] opcode_word(
        input logic [1:0] fmt,
        input logic [3:0] op,
        input logic [3:0] reg_sa,
        input logic       ad,
        input logic       bw,
        input logic [1:0] as_m,
        input logic [3:0] reg_da,
        input logic [9:0] offset
    );
        logic [15:0] w;
        w = 16'h0000;
        case (fmt)
            FMT_I:   w = {op, reg_sa, ad, bw, as_m, reg_da};
            FMT_II:  w = {FMT_II_PREFIX, op[2:0], bw, as_m, reg_da};
            FMT_J:   w = {JMP_PREFIX, op[2:0], offset};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_enc_if.sv
// Command and word-stream handshake bundle between the instruction source and the encoder.
// master = command producer / word consumer, slave = encoder.
interface instr_enc_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  FORMAT;
    logic [3:0]  op;
    logic [3:0]  reg_SA;
    logic [3:0]  reg_DA;
    logic        Ad;
    logic [1:0]  As;
    logic        BW;
    logic [9:0]  offset;
    logic [15:0] src_ext;
    logic [15:0] dst_ext;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        word_last;
    logic        err;

    modport master (
        output cmd_valid, FORMAT, op, reg_SA, reg_DA, Ad, As, BW, offset,
               src_ext, dst_ext, word_ready,
        input  cmd_ready, word_out, word_valid, word_last, err
    );

    modport slave (
        input  cmd_valid, FORMAT, op, reg_SA, reg_DA, Ad, As, BW, offset,
               src_ext, dst_ext, word_ready,
        output cmd_ready, word_out, word_valid, word_last, err
    );
endinterface

// File: rtl/instr_ext_len.sv
// Extension-word rule: which of the source/destination extension words an instruction carries.
// Kept standalone so the decoder can share the identical rule.
module instr_ext_len
    import instr_enc_pkg::*;
#(
    parameter logic [3:0] CG_REG = 4'd3,
    parameter logic [3:0] PC_REG = 4'd0
) (
    input  logic [1:0] format_i,
    input  logic [1:0] as_i,
    input  logic       ad_i,
    input  logic [3:0] reg_sa_i,
    input  logic [3:0] reg_da_i,
    output logic       need_src_o,
    output logic       need_dst_o
);

    logic [3:0] src_reg;
    logic       src_rule;

    // FMT_II has a single operand, encoded in the destination register field
    assign src_reg  = (format_i == FMT_II) ? reg_da_i : reg_sa_i;
    assign src_rule = ((as_i == 2'b01) && (src_reg != CG_REG)) ||
                      ((as_i == 2'b11) && (src_reg == PC_REG));

    always_comb begin
        need_src_o = 1'b0;
        need_dst_o = 1'b0;
        case (format_i)
            FMT_I: begin
                need_src_o = src_rule;
                need_dst_o = ad_i;
            end
            FMT_II:  need_src_o = src_rule;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_enc.sv
// MSP430 instruction encoder: latches one decoded instruction and streams its
// opcode word plus optional source/destination extension words.
module instr_enc
    import instr_enc_pkg::*;
#(
    parameter logic [3:0] CG_REG = 4'd3,
    parameter logic [3:0] PC_REG = 4'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_enc_if.slave        bus
);

    enc_state_e  state_q;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic        need_src_q;
    logic        need_dst_q;
    logic [15:0] word_out_q;
    logic        word_valid_q;
    logic        word_last_q;
    logic        err_q;
    logic        cmd_ready_q;

    logic        need_src_d;
    logic        need_dst_d;
    logic [15:0] opw_d;
    logic        reject_d;
    logic        fire;

    instr_ext_len #(
        .CG_REG (CG_REG),
        .PC_REG (PC_REG)
    ) u_ext_len (
        .format_i   (bus.FORMAT),
        .as_i       (bus.As),
        .ad_i       (bus.Ad),
        .reg_sa_i   (bus.reg_SA),
        .reg_da_i   (bus.reg_DA),
        .need_src_o (need_src_d),
        .need_dst_o (need_dst_d)
    );

    assign opw_d    = opcode_word(bus.FORMAT, bus.op, bus.reg_SA, bus.Ad, bus.BW,
                                  bus.As, bus.reg_DA, bus.offset);
    assign reject_d = cmd_invalid(bus.FORMAT, bus.op);
    assign fire     = word_valid_q & bus.word_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ENC_IDLE;
            src_q        <= 16'h0000;
            dst_q        <= 16'h0000;
            need_src_q   <= 1'b0;
            need_dst_q   <= 1'b0;
            word_out_q   <= 16'h0000;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            err_q        <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ENC_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (reject_d) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q      <= ENC_OPW;
                            src_q        <= bus.src_ext;
                            dst_q        <= bus.dst_ext;
                            need_src_q   <= need_src_d;
                            need_dst_q   <= need_dst_d;
                            word_out_q   <= opw_d;
                            word_valid_q <= 1'b1;
                            word_last_q  <= ~(need_src_d | need_dst_d);
                            cmd_ready_q  <= 1'b0;
                        end
                    end
                end
                ENC_OPW: begin
                    if (fire) begin
                        if (need_src_q) begin
                            state_q     <= ENC_SRC;
                            word_out_q  <= src_q;
                            word_last_q <= ~need_dst_q;
                        end else if (need_dst_q) begin
                            state_q     <= ENC_DST;
                            word_out_q  <= dst_q;
                            word_last_q <= 1'b1;
                        end else begin
                            state_q      <= ENC_IDLE;
                            word_out_q   <= 16'h0000;
                            word_valid_q <= 1'b0;
                            word_last_q  <= 1'b0;
                            cmd_ready_q  <= 1'b1;
                        end
                    end
                end
                ENC_SRC: begin
                    if (fire) begin
                        if (need_dst_q) begin
                            state_q     <= ENC_DST;
                            word_out_q  <= dst_q;
                            word_last_q <= 1'b1;
                        end else begin
                            state_q      <= ENC_IDLE;
                            word_out_q   <= 16'h0000;
                            word_valid_q <= 1'b0;
                            word_last_q  <= 1'b0;
                            cmd_ready_q  <= 1'b1;
                        end
                    end
                end
                ENC_DST: begin
                    if (fire) begin
                        state_q      <= ENC_IDLE;
                        word_out_q   <= 16'h0000;
                        word_valid_q <= 1'b0;
                        word_last_q  <= 1'b0;
                        cmd_ready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.word_out   = word_out_q;
    assign bus.word_valid = word_valid_q;
    assign bus.word_last  = word_last_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: directed MSP430 cases plus random commands
// compared against an arithmetic model of the encoding rules.
module tb_instr_enc;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    instr_enc_if bus();

    instr_enc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int fmt;
        int op;
        int sa;
        int da;
        int ad;
        int asm_;
        int bw;
        int off;
        int sx;
        int dx;
    } cmd_t;

    int exp_w [3];
    int exp_n;
    bit exp_rej;

    function automatic cmd_t mk(int fmt, int op, int sa, int da, int ad, int asm_,
                                int bw, int off, int sx, int dx);
        cmd_t c;
        c.fmt = fmt; c.op = op; c.sa = sa; c.da = da; c.ad = ad; c.asm_ = asm_;
        c.bw = bw; c.off = off; c.sx = sx; c.dx = dx;
        return c;
    endfunction

    // Reference: build the word list from the instruction-set rules with plain arithmetic
    task automatic model(input cmd_t c);
        int opw;
        int sreg;
        bit ns;
        bit nd;
        exp_rej = (c.fmt == 0) || (c.fmt == 2 && (c.op % 8) == 7);
        exp_n   = 0;
        if (!exp_rej) begin
            if (c.fmt == 1)
                opw = c.op * 4096 + c.sa * 256 + c.ad * 128 + c.bw * 64 + c.asm_ * 16 + c.da;
            else if (c.fmt == 2)
                opw = 4 * 1024 + (c.op % 8) * 128 + c.bw * 64 + c.asm_ * 16 + c.da;
            else
                opw = 1 * 8192 + (c.op % 8) * 1024 + c.off;
            sreg = (c.fmt == 1) ? c.sa : c.da;
            ns = (c.fmt != 3) && ((c.asm_ == 1 && sreg != 3) || (c.asm_ == 3 && sreg == 0));
            nd = (c.fmt == 1) && (c.ad == 1);
            exp_w[0] = opw;
            exp_n = 1;
            if (ns) begin exp_w[exp_n] = c.sx; exp_n++; end
            if (nd) begin exp_w[exp_n] = c.dx; exp_n++; end
        end
    endtask

    task automatic drive_cmd(input cmd_t c);
        bus.FORMAT  = 2'(c.fmt);
        bus.op      = 4'(c.op);
        bus.reg_SA  = 4'(c.sa);
        bus.reg_DA  = 4'(c.da);
        bus.Ad      = 1'(c.ad);
        bus.As      = 2'(c.asm_);
        bus.BW      = 1'(c.bw);
        bus.offset  = 10'(c.off);
        bus.src_ext = 16'(c.sx);
        bus.dst_ext = 16'(c.dx);
    endtask

    task automatic scramble_cmd();
        bus.FORMAT  = 2'($urandom);
        bus.op      = 4'($urandom);
        bus.reg_SA  = 4'($urandom);
        bus.reg_DA  = 4'($urandom);
        bus.Ad      = 1'($urandom);
        bus.As      = 2'($urandom);
        bus.BW      = 1'($urandom);
        bus.offset  = 10'($urandom);
        bus.src_ext = 16'($urandom);
        bus.dst_ext = 16'($urandom);
    endtask

    // Issue one command, then consume its stream holding word_ready low for 'stall' cycles per word
    task automatic do_instr(input string name, input cmd_t c, input int stall);
        model(c);
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cmd_ready before accept: got %b want 1", name, bus.cmd_ready);
        end
        drive_cmd(c);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        scramble_cmd();
        if (exp_rej) begin
            checks++;
            if (bus.err !== 1'b1 || bus.word_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s reject: err=%b valid=%b ready=%b want 1 0 1",
                         name, bus.err, bus.word_valid, bus.cmd_ready);
            end
            @(negedge clk);
            checks++;
            if (bus.err !== 1'b0 || bus.word_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s err pulse width: err=%b valid=%b want 0 0",
                         name, bus.err, bus.word_valid);
            end
            return;
        end
        for (int i = 0; i < exp_n; i++) begin
            for (int s = 0; s < stall; s++) begin
                bus.word_ready = 1'b0;
                checks++;
                if (bus.word_valid !== 1'b1 || bus.word_out !== 16'(exp_w[i])) begin
                    errors++;
                    $display("FAIL %s stall word%0d: valid=%b out=%h want 1 %h",
                             name, i, bus.word_valid, bus.word_out, 16'(exp_w[i]));
                end
                @(negedge clk);
            end
            bus.word_ready = 1'b1;
            checks++;
            if (bus.word_valid !== 1'b1 || bus.word_out !== 16'(exp_w[i]) ||
                bus.word_last !== (i == exp_n - 1) || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s word%0d: valid=%b out=%h last=%b ready=%b want 1 %h %b 0",
                         name, i, bus.word_valid, bus.word_out, bus.word_last,
                         bus.cmd_ready, 16'(exp_w[i]), (i == exp_n - 1));
            end
            @(negedge clk);
            bus.word_ready = 1'b0;
        end
        checks++;
        if (bus.word_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL %s end of stream: valid=%b ready=%b err=%b want 0 1 0",
                     name, bus.word_valid, bus.cmd_ready, bus.err);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.word_valid !== 1'b0 || bus.word_last !== 1'b0 ||
            bus.err !== 1'b0 || bus.word_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b last=%b err=%b out=%h want 1 0 0 0 0000",
                     bus.cmd_ready, bus.word_valid, bus.word_last, bus.err, bus.word_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mov_imm();
        do_instr("mov_imm", mk(1, 4, 0, 5, 0, 3, 0, 0, 16'h1234, 0), 0);
    endtask

    task automatic test_add_stall();
        do_instr("add_idx_stall", mk(1, 5, 4, 6, 1, 0, 0, 0, 0, 16'h0002), 3);
    endtask

    task automatic test_cg();
        do_instr("mov_cg", mk(1, 4, 3, 7, 0, 1, 0, 0, 16'hAAAA, 16'h5555), 0);
    endtask

    task automatic test_jump_push();
        do_instr("jne", mk(3, 0, 0, 0, 0, 0, 0, 10'h3FE, 16'h1111, 16'h2222), 1);
        do_instr("push_imm", mk(2, 4, 0, 0, 0, 3, 0, 0, 16'hBEEF, 16'h3333), 0);
    endtask

    task automatic test_reject();
        do_instr("rej_fmt0", mk(0, 4, 1, 2, 1, 1, 0, 0, 16'h1, 16'h2), 0);
        do_instr("rej_fmt2_op7", mk(2, 7, 0, 5, 0, 1, 1, 0, 16'h1, 16'h2), 0);
    endtask

    task automatic test_reset_mid();
        cmd_t c;
        c = mk(1, 4, 5, 7, 1, 1, 0, 0, 16'h0004, 16'h0006);
        model(c);
        @(negedge clk);
        drive_cmd(c);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.word_ready = 1'b1;
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 16'(exp_w[0])) begin
            errors++;
            $display("FAIL rstmid opw: valid=%b out=%h want 1 %h",
                     bus.word_valid, bus.word_out, 16'(exp_w[0]));
        end
        @(negedge clk);
        bus.word_ready = 1'b0;
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 16'(exp_w[1]) || bus.word_last !== 1'b0) begin
            errors++;
            $display("FAIL rstmid src: valid=%b out=%h last=%b want 1 %h 0",
                     bus.word_valid, bus.word_out, bus.word_last, 16'(exp_w[1]));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.word_valid !== 1'b0 || bus.word_last !== 1'b0 || bus.err !== 1'b0 ||
            bus.cmd_ready !== 1'b1 || bus.word_out !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid abort: valid=%b last=%b err=%b ready=%b out=%h want 0 0 0 1 0000",
                     bus.word_valid, bus.word_last, bus.err, bus.cmd_ready, bus.word_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.word_valid !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid release: ready=%b valid=%b err=%b want 1 0 0",
                     bus.cmd_ready, bus.word_valid, bus.err);
        end
        do_instr("after_rst", mk(1, 4, 3, 7, 0, 1, 0, 0, 16'h0, 16'h0), 0);
    endtask

    task automatic test_back_to_back();
        do_instr("b2b_a", mk(1, 4, 5, 7, 1, 1, 1, 0, 16'h0004, 16'h0006), 0);
        do_instr("b2b_b", mk(2, 0, 0, 9, 0, 1, 0, 0, 16'h00F0, 16'h0), 0);
        do_instr("b2b_c", mk(1, 15, 0, 12, 1, 3, 1, 0, 16'hCAFE, 16'hF00D), 2);
    endtask

    task automatic test_random();
        cmd_t c;
        for (int n = 0; n < 60; n++) begin
            c = mk($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1023),
                   $urandom_range(0, 65535), $urandom_range(0, 65535));
            // bias toward the special registers so the CG/PC rules get exercised
            if ($urandom_range(0, 2) == 0) c.sa = ($urandom_range(0, 1) == 0) ? 0 : 3;
            if ($urandom_range(0, 2) == 0) c.da = ($urandom_range(0, 1) == 0) ? 0 : 3;
            do_instr("random", c, $urandom_range(0, 2));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.word_ready = 1'b0;
        scramble_cmd();
        @(negedge clk);
        test_reset();
        test_mov_imm();
        test_add_stall();
        test_cg();
        test_jump_push();
        test_reject();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_enc.md
Name: instr_enc

Overview:
Instruction encoder, the inverse of the instruction decoder. It accepts one decoded MSP430 instruction as a set of fields and emits the matching word stream, one 16-bit word per accepted transfer. The stream is the opcode word, then the source extension word if the mode needs one, then the destination extension word if the mode needs one. It sits between the boot loader / test stimulus path and program-memory writes, so its stream is exactly what the decoder consumes from the MDB.

Parameters:
CG_REG, 3, register number of the constant generator; As=01 on this register needs no extension word.
PC_REG, 0, register number of the PC; As=11 on this register is immediate and needs an extension word.

Ports:
clk  input  1  system clock; all state changes on posedge.
rst_n  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command fields below are valid.
cmd_ready  output  1  encoder can accept a command (IDLE only).
FORMAT  input  2  1=FMT_I, 2=FMT_II, 3=FMT_J; 0 is invalid.
op  input  4  FMT_I opcode [15:12]; FMT_II uses op[2:0] as [9:7]; FMT_J uses op[2:0] as the condition [12:10].
reg_SA  input  4  source register (FMT_I only).
reg_DA  input  4  destination register (FMT_I and FMT_II).
Ad  input  1  destination addressing mode bit (FMT_I only).
As  input  2  source addressing mode (FMT_I); operand addressing mode (FMT_II).
BW  input  1  byte/word select.
offset  input  10  jump offset, two's complement word count.
src_ext  input  16  source (FMT_II: operand) extension word.
dst_ext  input  16  destination extension word.
word_out  output  16  emitted word.
word_valid  output  1  word_out is valid.
word_ready  input  1  consumer accepts word_out.
word_last  output  1  current word is the final word of this instruction.
err  output  1  one-cycle pulse: command rejected.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cmd_ready=1, word_valid=0, word_last=0, err=0, word_out=0. All latched fields are cleared.
- Accept: when cmd_valid & cmd_ready, all fields are latched and the encoder computes:
  - FMT_I opcode word: {op, reg_SA, Ad, BW, As, reg_DA}.
  - FMT_II opcode word: {6'b000100, op[2:0], BW, As, reg_DA}.
  - FMT_J opcode word: {3'b001, op[2:0], offset}.
- Extension words needed:
  - need_src, FMT_I: (As==01 & reg_SA!=CG_REG) | (As==11 & reg_SA==PC_REG).
  - need_src, FMT_II: the same rule applied to reg_DA.
  - need_dst: FMT_I & Ad.
  - FMT_J: neither.
  - Total length is 1 to 3 words.
- Reject: FORMAT==0, or FMT_II with op[2:0]==3'b111, raises err for one cycle. No words are emitted and the state stays IDLE.
- State machine: IDLE -> OPW -> (SRC) -> (DST) -> IDLE.
  - The encoder enters OPW on the cycle after accept, so latency from accept to first word_valid is 1 cycle.
  - In each emitting state, word_valid=1 and word_out holds that state's word.
  - A state advances only when word_valid & word_ready. Otherwise word_out and word_valid are held stable; a stall holds indefinitely.
  - From OPW the next state is SRC if need_src, else DST if need_dst, else IDLE. From SRC the next state is DST if need_dst, else IDLE.
- word_last=1 in the final emitting state of the sequence.
- cmd_ready=1 only in IDLE. There is no back-to-back overlap: after the final handshake the state returns to IDLE, and the next command can be accepted one cycle later.
- Input fields may change after accept; only the latched copies are used.
- Reset mid-sequence: the sequence is aborted immediately, with no partial word and no err.

Decomposition:
- Extend msp430_ops.vh with:
  - FMT_I/FMT_II/FMT_J constants (1/2/3), promoted out of decoder-local parameters.
  - The FMT_II prefix 6'b000100 and the jump prefix 3'b001.
  - State encodings ENC_IDLE/ENC_OPW/ENC_SRC/ENC_DST.
- One combinational sub-module, instr_ext_len. Inputs: FORMAT, As, Ad, reg_SA, reg_DA. Outputs: need_src, need_dst. The decoder will later share the same rule.

Test Plan:
- MOV #0x1234,R5 (FMT_I, op=4, SA=0, Ad=0, As=11, DA=5, src_ext=0x1234), word_ready=1 -> words 0x4035 then 0x1234; word_last on the second word.
- ADD R4,2(R6) (op=5, SA=4, Ad=1, As=00, DA=6, dst_ext=0x0002), with word_ready low for 3 cycles on each word -> 0x5486 then 0x0002, word_out stable throughout each stall.
- MOV #1,R7 via constant generator (SA=3, As=01, DA=7) -> single word 0x4317, word_last=1, no extension word.
- JNE offset -2 (FORMAT=3, op=0, offset=0x3FE) -> single word 0x23FE. PUSH #imm (FORMAT=2, op=4, As=11, DA=0, src_ext=0xBEEF) -> 0x1230 then 0xBEEF.
- FORMAT=0, and FORMAT=2 with op=7 -> err pulses one cycle each, word_valid stays 0, cmd_ready stays 1.
- 3-word MOV 4(R5),6(R7), assert rst_n=0 during SRC -> word_valid=0 immediately; after release, cmd_ready=1 and the next command encodes cleanly.
